// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port request/grant arbiter in front of a single-port memory.
// Port 0 is instruction fetch, port 1 is data. One access is in flight at a
// time. The memory lines are driven for LAT cycles, then a one-cycle ack is
// returned to the winner.
// Configuration macro: MEM_ARB_RR_EN selects round-robin arbitration; when it
// is undefined, port 0 has fixed priority over port 1.
module mem_arbiter #(
    parameter int AW  = 8,
    parameter int DW  = 8,
    parameter int LAT = 1   // memory access latency, 1..15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    req,
    input  logic [1:0]    we,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic [1:0]    gnt,
    output logic [1:0]    ack,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    state_t        state, state_d;
    logic [1:0]    gnt_d, ack_d;
    logic [DW-1:0] rdata_d;
    logic          mem_en_d, mem_we_d;
    logic [AW-1:0] mem_addr_d;
    logic [DW-1:0] mem_wdata_d;
    logic          last, last_d;   // port that won the most recent grant
    logic [3:0]    cnt, cnt_d;     // remaining BUSY cycles after this one
    logic          win;            // winner if a grant is made this cycle

    // Arbitration: choose the winning port from the current requests.
`ifdef MEM_ARB_RR_EN
    always_comb begin
        // Both requesting: the port that did not win last time; otherwise the
        // sole requester.
        win = (req == 2'b11) ? ~last : req[1];
    end
`else
    always_comb begin
        // Port 0 always beats port 1.
        win = ~req[0];
    end
`endif

    // Next-state and next-output logic for the IDLE/BUSY/ACK sequencer.
    always_comb begin
        // NOTE: every target gets a default first, so no path leaves a
        // variable unassigned and no latch is inferred.
        state_d     = state;
        gnt_d       = gnt;
        ack_d       = ack;
        rdata_d     = rdata;
        mem_en_d    = mem_en;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        last_d      = last;
        cnt_d       = cnt;
        unique case (state)
            IDLE: begin
                if (|req) begin
                    gnt_d       = win ? 2'b10 : 2'b01;
                    mem_en_d    = 1'b1;
                    mem_we_d    = we[win];
                    mem_addr_d  = win ? addr1 : addr0;
                    mem_wdata_d = win ? wdata1 : wdata0;
                    cnt_d       = 4'(LAT - 1);
                    last_d      = win;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (cnt != 4'd0) begin
                    cnt_d = cnt - 4'd1;
                end else begin
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    ack_d    = gnt;
                    // Writes leave the last read data in place.
                    if (!mem_we) rdata_d = mem_rdata;
                    state_d = ACK;
                end
            end
            ACK: begin
                ack_d   = 2'b00;
                gnt_d   = 2'b00;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            ack       <= '0;
            rdata     <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            last      <= 1'b1;
            cnt       <= '0;
        end else begin
            state     <= state_d;
            gnt       <= gnt_d;
            ack       <= ack_d;
            rdata     <= rdata_d;
            mem_en    <= mem_en_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            last      <= last_d;
            cnt       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a scoreboard of expected acks.
// Stimulus pushes the expected ack port, read data and ack cycle; a monitor
// pops and compares whenever ack is raised. A small memory array stands in
// for the storage. Build with or without MEM_ARB_RR_EN.
module tb_mem_arbiter;

    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req, we;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic [1:0]    gnt, ack;
    logic [DW-1:0] rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    mem_arbiter #(.AW(AW), .DW(DW), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt(gnt), .ack(ack), .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Number of rising edges so far; read on falling edges.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Storage model: combinational read, write on strobed edges.
    logic [DW-1:0] mem [256];
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [1:0] ack;
        logic [7:0] rdata;
        int         cyc;
    } exp_t;
    exp_t sb[$];

    // Monitor: invariants every cycle, scoreboard compare on each ack.
    always @(negedge clk) begin
        exp_t e;
        check("gnt_onehot", 32'($onehot0(gnt)), 1);
        check("ack_within_gnt", 32'((ack & ~gnt) == 2'b00), 1);
        if (ack != 2'b00) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", ack, 0);
            end else begin
                e = sb.pop_front();
                check("ack_port", ack, e.ack);
                check("ack_rdata", rdata, e.rdata);
                check("ack_cycle", cyc, e.cyc);
            end
        end
    end

    // One access from an idle FSM; called and returns on a falling edge.
    task automatic issue(input logic [1:0] rq, input logic [1:0] wv, input int win,
                         input logic [7:0] exp_rd, input string tag);
        logic [1:0] oh;
        logic [7:0] ea, ed;
        int e0;
        oh = (win == 1) ? 2'b10 : 2'b01;
        ea = (win == 1) ? addr1 : addr0;
        ed = (win == 1) ? wdata1 : wdata0;
        req = rq;
        we  = wv;
        @(negedge clk);
        e0 = cyc;
        check({tag, "_gnt"}, gnt, oh);
        check({tag, "_mem_en"}, mem_en, 1);
        check({tag, "_mem_we"}, mem_we, wv[win]);
        check({tag, "_mem_addr"}, mem_addr, ea);
        if (wv[win]) check({tag, "_mem_wdata"}, mem_wdata, ed);
        sb.push_back('{oh, exp_rd, e0 + LAT});
        // Drop the request and disturb the port inputs: the access in
        // progress must not notice.
        req = 2'b00;
        addr0 = ~addr0; addr1 = ~addr1; wdata0 = ~wdata0; wdata1 = ~wdata1;
        for (int j = 1; j <= LAT + 1; j++) begin
            @(negedge clk);
            check({tag, "_gnt_hold"}, gnt, (j <= LAT) ? oh : 2'b00);
            check({tag, "_mem_en_len"}, mem_en, 32'(j < LAT));
            check({tag, "_mem_we_len"}, mem_we, 32'((j < LAT) && wv[win]));
            check({tag, "_mem_addr_hold"}, mem_addr, ea);
        end
    endtask

    initial begin
        int c;
        logic [1:0] oh;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h77;
        mem[8'h3C] = 8'hA5;
        mem[8'h20] = 8'h11;
        mem[8'h21] = 8'h22;
        rst = 1'b1; req = 2'b11; we = 2'b00;
        addr0 = 8'h00; addr1 = 8'h00; wdata0 = 8'h00; wdata1 = 8'h00;

        // Reset held two cycles with both ports requesting.
        repeat (2) begin
            @(negedge clk);
            check("rst_ctrl", {gnt, ack, mem_en, mem_we}, 6'b0);
            check("rst_rdata", rdata, 0);
            check("rst_mem_addr", mem_addr, 0);
            check("rst_mem_wdata", mem_wdata, 0);
        end
        rst = 1'b0;
        issue(2'b11, 2'b00, 0, 8'h77, "first_after_rst");

        // Single read on port 1.
        addr1 = 8'h3C;
        issue(2'b10, 2'b00, 1, 8'hA5, "p1_read");

        // Write then read back on port 0; the write leaves rdata at A5.
        addr0 = 8'h10; wdata0 = 8'h5A;
        issue(2'b01, 2'b01, 0, 8'hA5, "p0_write");
        addr0 = 8'h10;
        issue(2'b01, 2'b00, 0, 8'h5A, "p0_readback");

        // Reset one cycle into an access: no ack, memory strobe dropped.
        addr0 = 8'h30; req = 2'b01; we = 2'b00;
        @(negedge clk);
        check("abort_gnt", gnt, 2'b01);
        rst = 1'b1; req = 2'b00;
        @(negedge clk);
        check("abort_mem_en", mem_en, 0);
        check("abort_gnt_clr", gnt, 0);
        check("abort_ack", ack, 0);
        rst = 1'b0;
        repeat (LAT + 3) @(negedge clk);
        check("abort_rdata", rdata, 0);

        // Contention: both ports request continuously for four accesses.
        addr0 = 8'h20; addr1 = 8'h21; we = 2'b00; req = 2'b11;
        c = cyc;
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
            oh = (k % 2 == 1) ? 2'b10 : 2'b01;
`else
            oh = 2'b01;
`endif
            sb.push_back('{oh, (oh == 2'b10) ? 8'h22 : 8'h11, c + 1 + LAT + k * (LAT + 2)});
        end
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
            oh = (k % 2 == 1) ? 2'b10 : 2'b01;
`else
            oh = 2'b01;
`endif
            check("contend_gnt", gnt, oh);
            check("contend_period", cyc, c + 1 + k * (LAT + 2));
            if (k < 3) repeat (LAT + 2) @(negedge clk);
        end
        req = 2'b00;
        repeat (LAT + 2) @(negedge clk);

        // Port 0 holds req one cycle past its ack: a second access follows.
        addr0 = 8'h00; we = 2'b00; req = 2'b01;
        @(negedge clk);
        c = cyc;
        check("late_gnt", gnt, 2'b01);
        sb.push_back('{2'b01, 8'h77, c + LAT});
        sb.push_back('{2'b01, 8'h77, c + 2 * LAT + 2});
        repeat (LAT + 1) @(negedge clk);
        check("late_idle_gap", gnt, 0);
        @(negedge clk);
        check("late_regrant", gnt, 2'b01);
        req = 2'b00;
        repeat (LAT + 2) @(negedge clk);
        check("late_done_gnt", gnt, 0);

        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port request/grant arbiter that shares one single-port storage array (the D-type register memory) between the instruction-fetch port (port 0) and the data port (port 1). It serialises accesses, drives the memory control, address and data lines for a fixed access latency, and returns read data with a one-cycle acknowledge to the winning requester. It sits between the CPU core's fetch/load-store units and the memory array.

## Interface
- `AW`, 8: address width.
- `DW`, 8: data width.
- `LAT`, 1: memory access latency in cycles; legal range 1..15.

- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in 2: per-port request; bit i = port i.
- `we` in 2: per-port write enable, qualified by `req`.
- `addr0`, `addr1` in AW: per-port address.
- `wdata0`, `wdata1` in DW: per-port write data.
- `gnt` out 2: one-hot grant, held for the whole access.
- `ack` out 2: one-hot, one-cycle completion pulse.
- `rdata` out DW: read data, valid while `ack` is high, held afterwards.
- `mem_en` out 1: memory access strobe.
- `mem_we` out 1: memory write strobe.
- `mem_addr` out AW: memory address.
- `mem_wdata` out DW: memory write data.
- `mem_rdata` in DW: memory read data, valid after `LAT` cycles of `mem_en`.

## Operation
- All outputs are registered.
- On `rst`: state IDLE, `gnt`=0, `ack`=0, `rdata`=0, `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `last`=1, `cnt`=0.
- FSM states: IDLE, BUSY, ACK.
- IDLE:
  - No `req` bit set: remain in IDLE.
  - Any `req` bit set: pick winner w.
  - Latch `addr_w`, `wdata_w`, `we[w]` into the `mem_*` outputs.
  - Set `gnt[w]`=1, `mem_en`=1, `mem_we`=`we[w]`, `cnt`=LAT-1, `last`=w; go to BUSY.
- BUSY:
  - `cnt`≠0: decrement `cnt` and hold all outputs.
  - `cnt`=0: set `mem_en`=0 and `mem_we`=0, and `ack[w]`=1.
  - On that same `cnt`=0 edge, a read captures `rdata`←`mem_rdata`; a write leaves `rdata` unchanged. Go to ACK.
- ACK: set `ack`=0 and `gnt`=0; go to IDLE.
- `req` is ignored in BUSY and ACK.
- A requester must drop `req` on the edge where it samples `ack`; if it does not, the request is treated as a new access.
- Changes to a requester's inputs after it is granted have no effect on the access in progress.
- Reset mid-access: the access is aborted, no `ack` is issued, and `mem_en` is low after the reset edge.

## Timing
- `req` is sampled at edge E0. `gnt` and `mem_en` go high after E0.
- `mem_en` stays high for exactly LAT cycles.
- `ack` and `rdata` become valid after edge E0+LAT, for one cycle.
- `gnt` falls after edge E0+LAT+1, and the FSM is back in IDLE at that point.
- The earliest next grant is sampled at edge E0+LAT+2, so back-to-back accesses have a period of LAT+2 cycles.
- `gnt` and `ack` are never high on both ports at once. `ack[i]` only occurs while `gnt[i]`=1.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration. When both ports request, the grant goes to the port ≠ `last`; a single requester always wins. Port 0 wins first after reset.
- `MEM_ARB_RR_EN` undefined: fixed priority, port 0 always beats port 1. The `last` register is still maintained but not used.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with `req`=2'b11 → all outputs 0 and no `gnt` during reset. First grant after release goes to port 0.
- Single read, LAT=1: port 1 reads addr 8'h3C with `mem_rdata`=8'hA5 → `gnt`=2'b10 and `mem_addr`=8'h3C after E0; `ack`=2'b10 and `rdata`=8'hA5 after E0+1; `gnt`=0 after E0+2.
- Write then read, LAT=3: port 0 writes 8'h5A to 8'h10 → `mem_we`=1 for 3 cycles, `ack` after E0+3, `rdata` unchanged. Port 0 then reads 8'h10 with the memory model returning 8'h5A → `rdata`=8'h5A.
- Contention: hold `req`=2'b11 continuously for 4 accesses.
  - With `MEM_ARB_RR_EN`: grants go 0,1,0,1 with a period of LAT+2.
  - Without it: grants go 0,0,0,0 and port 1 is starved.
- Reset mid-access, LAT=4: assert `rst` one cycle after a grant → no `ack` ever appears; `mem_en`=0 and `gnt`=0 on the cycle after the reset edge.
- Late request drop: port 0 keeps `req` high one cycle past its `ack` → a second port-0 access is granted at E0+LAT+2, and `ack` and `gnt` stay one-hot throughout.
